// File: rtl/iter_muldiv.sv
// Iterative multiply/divide unit beside the EX stage.
// MULT: radix-2 shift-add of operand magnitudes into a 2*WIDTH accumulator.
// DIV: restoring radix-2 division producing {remainder, quotient}.
// Both take WIDTH iterations. Signs are fixed up on the final iteration.
// Outputs are registered from the state, so ready_o rises one edge after
// the FSM enters StDone and falls one edge after it leaves.
module iter_muldiv #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               op_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_by_zero_o
);

  typedef enum logic [1:0] {StIdle, StDzero, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic               op_q;       // 0 = MULT, 1 = DIV
  logic               neg_lo_q;   // product / quotient must be negated
  logic               neg_hi_q;   // remainder must be negated
  logic               dz_flag_q;
  logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;      // working accumulator, holds the result in StDone
  logic [CNT_W-1:0]   cnt_q;

  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic               dzo_q, dzo_d;

  // Operand capture: magnitudes and sign bookkeeping
  logic             sign1, sign2;
  logic [WIDTH-1:0] mag1, mag2;
  logic             capture;
  logic             last_iter;

  assign sign1     = signed_i & opdata1_i[WIDTH-1];
  assign sign2     = signed_i & opdata2_i[WIDTH-1];
  // The most-negative value negates to itself, which is its correct unsigned magnitude.
  assign mag1      = sign1 ? -opdata1_i : opdata1_i;
  assign mag2      = sign2 ? -opdata2_i : opdata2_i;
  assign capture   = (state_q == StIdle) && start_i && !annul_i;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // One iteration of each algorithm plus the sign-corrected final value
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   div_diff;
  logic               div_borrow;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [2*WIDTH-1:0] step_next, final_next;

  always_comb begin
    // MULT: add multiplicand into the high half when the multiplier LSB is set, shift right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // DIV: the shifted partial remainder needs WIDTH+1 bits; an extra bit catches the borrow.
    rem_sh     = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff   = {1'b0, rem_sh} - {2'b00, opnd_q};
    div_borrow = div_diff[WIDTH+1];
    div_rem    = div_borrow ? rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
    div_next   = {div_rem, acc_q[WIDTH-2:0], ~div_borrow};

    quo_fix = neg_lo_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    rem_fix = neg_hi_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

    step_next  = op_q ? div_next : mul_next;
    final_next = op_q ? {rem_fix, quo_fix} : (neg_lo_q ? -mul_next : mul_next);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (capture) begin
          state_d = (op_i && (opdata2_i == '0)) ? StDzero : StRun;
        end
      end
      StDzero: state_d = annul_i ? StIdle : StDone;
      StRun: begin
        if (annul_i) begin
          state_d = StIdle;
        end else if (last_iter) begin
          state_d = StDone;
        end
      end
      StDone: state_d = start_i ? StDone : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: capture in StIdle, iterate in StRun, hold in StDone
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      dz_flag_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (capture) begin
            op_q      <= op_i;
            neg_lo_q  <= sign1 ^ sign2;
            neg_hi_q  <= sign1;
            dz_flag_q <= 1'b0;
            opnd_q    <= op_i ? mag2 : mag1;
            acc_q     <= {{WIDTH{1'b0}}, (op_i ? mag1 : mag2)};
            cnt_q     <= '0;
          end
        end
        StDzero: begin
          acc_q     <= '0;
          dz_flag_q <= 1'b1;
        end
        StRun: begin
          acc_q <= last_iter ? final_next : step_next;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        StDone: begin
          acc_q <= acc_q;
        end
        default: begin
          acc_q <= '0;
        end
      endcase
    end
  end

  // Output decode; busy also covers the cycle where the registered ready is draining
  always_comb begin
    ready_d  = (state_q == StDone);
    result_d = ready_d ? acc_q : '0;
    dzo_d    = ready_d & dz_flag_q;
    busy_o   = (state_q != StIdle) | ready_q;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q  <= 1'b0;
      result_q <= '0;
      dzo_q    <= 1'b0;
    end else begin
      ready_q  <= ready_d;
      result_q <= result_d;
      dzo_q    <= dzo_d;
    end
  end

  assign ready_o       = ready_q;
  assign result_o      = result_q;
  assign div_by_zero_o = dzo_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed bench for iter_muldiv: a WIDTH=32 instance and a WIDTH=8 instance.
module tb_iter_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start = 1'b0, annul = 1'b0, op = 1'b0, sgn = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [63:0] res;
  logic        ready, busy, dz;

  logic        start8 = 1'b0, annul8 = 1'b0, op8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] res8;
  logic        ready8, busy8, dz8;

  int checks = 0;
  int failures = 0;
  int rises;

  always #5 clk = ~clk;

  iter_muldiv #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .op_i(op), .signed_i(sgn),
    .opdata1_i(a), .opdata2_i(b), .result_o(res), .ready_o(ready), .busy_o(busy),
    .div_by_zero_o(dz)
  );

  iter_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .annul_i(annul8), .op_i(op8), .signed_i(sgn8),
    .opdata1_i(a8), .opdata2_i(b8), .result_o(res8), .ready_o(ready8), .busy_o(busy8),
    .div_by_zero_o(dz8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation on the 32-bit unit; E0 is the first edge after start rises.
  task automatic run_op(input string tag, input logic o, input logic s,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp_res, input logic exp_dz, input int lat);
    op = o; sgn = s; a = x; b = y; start = 1'b1;
    tick();  // E0
    check({tag, ":busy_e0"}, 64'(busy), 64'd1);
    repeat (lat - 1) tick();
    check({tag, ":ready_early"}, 64'(ready), 64'd0);
    tick();  // E(lat)
    check({tag, ":ready"}, 64'(ready), 64'd1);
    check({tag, ":result"}, res, exp_res);
    check({tag, ":dz"}, 64'(dz), 64'(exp_dz));
    check({tag, ":busy_done"}, 64'(busy), 64'd1);
    // Start held and operands scrambled: result must stay put, no re-issue.
    a = ~x; b = x; op = ~o;
    repeat (3) tick();
    check({tag, ":hold_ready"}, 64'(ready), 64'd1);
    check({tag, ":hold_result"}, res, exp_res);
    start = 1'b0;
    tick();
    tick();
    check({tag, ":ready_drop"}, 64'(ready), 64'd0);
    check({tag, ":busy_drop"}, 64'(busy), 64'd0);
    check({tag, ":result_drop"}, res, 64'd0);
    tick();
  endtask

  initial begin
    repeat (2) tick();
    check("reset:ready", 64'(ready), 64'd0);
    check("reset:busy", 64'(busy), 64'd0);
    check("reset:result", res, 64'd0);
    check("reset:dz", 64'(dz), 64'd0);
    rst = 1'b0;
    tick();

    run_op("div_u_100_7", 1'b1, 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 33);
    run_op("div_s_m7_2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 33);
    run_op("div_s_minneg", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF,
           64'h00000000_80000000, 1'b0, 33);
    run_op("div_u_minneg", 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF,
           64'h80000000_00000000, 1'b0, 33);
    run_op("div_by_zero", 1'b1, 1'b0, 32'd5, 32'd0, 64'd0, 1'b1, 2);
    run_op("mul_s_m3_5", 1'b0, 1'b1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b0, 33);
    run_op("mul_u_max", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
           64'hFFFFFFFE_00000001, 1'b0, 33);
    run_op("mul_s_max", 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1, 1'b0, 33);

    // Annul mid-division: back to idle, ready never rises.
    op = 1'b1; sgn = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();  // E0
    repeat (10) tick();
    start = 1'b0; annul = 1'b1;
    tick();  // E11
    annul = 1'b0;
    check("annul:busy", 64'(busy), 64'd0);
    rises = 0;
    repeat (40) begin
      tick();
      if (ready === 1'b1) rises++;
    end
    check("annul:no_ready", 64'(rises), 64'd0);
    run_op("after_annul", 1'b1, 1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 1'b0, 33);

    // Synchronous reset mid-division clears everything.
    op = 1'b1; sgn = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();  // E0
    repeat (9) tick();
    rst = 1'b1;
    tick();  // E10
    check("rst_mid:ready", 64'(ready), 64'd0);
    check("rst_mid:busy", 64'(busy), 64'd0);
    check("rst_mid:result", res, 64'd0);
    check("rst_mid:dz", 64'(dz), 64'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    run_op("after_rst", 1'b0, 1'b0, 32'd12345, 32'd1000, 64'd12345000, 1'b0, 33);

    // WIDTH=8 unit: 200/3 with operands disturbed during RUN.
    op8 = 1'b1; sgn8 = 1'b0; a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
    tick();  // E0
    a8 = 8'd5; b8 = 8'd1; op8 = 1'b0; sgn8 = 1'b1;
    repeat (8) tick();
    check("w8_div:ready_early", 64'(ready8), 64'd0);
    tick();  // E9
    check("w8_div:ready", 64'(ready8), 64'd1);
    check("w8_div:result", 64'(res8), 64'h0242);
    check("w8_div:dz", 64'(dz8), 64'd0);
    start8 = 1'b0;
    tick();
    tick();
    check("w8_div:ready_drop", 64'(ready8), 64'd0);

    // WIDTH=8 signed corner: -128 / -1.
    op8 = 1'b1; sgn8 = 1'b1; a8 = 8'h80; b8 = 8'hFF; start8 = 1'b1;
    tick();  // E0
    repeat (9) tick();
    check("w8_corner:ready", 64'(ready8), 64'd1);
    check("w8_corner:result", 64'(res8), 64'h0080);
    start8 = 1'b0;
    tick();
    tick();
    check("w8_corner:busy_drop", 64'(busy8), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iter_muldiv.md
Name: iter_muldiv

Overview:
- Parametrised iterative multiply/divide unit; successor to the fixed 32-bit divider used beside the EX stage.
- Adds a configurable operand width, a multiply mode and a divide-by-zero flag, keeping the same start/annul/ready handshake.
- EX drives op/start and holds start through its stall. The unit returns a 2*WIDTH result, which EX splits into hi/lo for the HILO path.

Parameters:
- WIDTH, 32, operand width in bits (>=2); result is 2*WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  request; sampled only in IDLE; must stay high until ready_o is seen.
- annul_i  in  1  abort current operation.
- op_i  in  1  0 = MULT, 1 = DIV.
- signed_i  in  1  1 = two's-complement operands.
- opdata1_i  in  WIDTH  multiplicand / dividend.
- opdata2_i  in  WIDTH  multiplier / divisor.
- result_o  out  2*WIDTH  MULT: full product {hi,lo}. DIV: {remainder, quotient}.
- ready_o  out  1  result valid.
- busy_o  out  1  high in DZERO, RUN and DONE.
- div_by_zero_o  out  1  qualifies ready_o for a DIV by 0.

Behaviour:
- Reset: on any edge with rst=1, state goes to IDLE and all outputs are 0. This overrides every other input, including mid-operation.
- States: IDLE, DZERO, RUN, DONE.
- IDLE, start_i=1 and annul_i=0:
  - Latch op, signed flag and operand magnitudes (negate if signed and MSB=1).
  - Record result signs: product/quotient negative = XOR of operand signs; remainder sign = dividend sign.
  - DIV with opdata2_i==0 goes to DZERO; otherwise go to RUN with cnt=0.
- IDLE, otherwise: stay; outputs 0.
- RUN: one bit per edge, cnt increments, WIDTH edges total. On the edge where cnt==WIDTH-1, apply sign correction and go to DONE.
  - DIV: restoring radix-2. Shift {rem, quo} left by 1, trial-subtract the divisor magnitude, set the quotient LSB on no borrow.
  - MULT: shift-add of magnitudes into a 2*WIDTH accumulator.
- DZERO: next edge goes to DONE with result 0 and div_by_zero_o=1.
- DONE: ready_o=1; result_o and div_by_zero_o are held stable.
  - Leave DONE on the first edge with start_i=0; all outputs return to 0 in the following cycle.
  - While start_i stays high, remain in DONE; no re-issue occurs.
- annul_i=1 in DZERO or RUN: next edge goes to IDLE, no ready_o pulse. annul_i in DONE has no effect.
- Latency, counted from the capturing edge E0:
  - MULT/DIV: ready_o high after edge E(WIDTH+1).
  - DIV by zero: ready_o high after edge E2.
- Operands and op_i are ignored after capture. start_i seen outside IDLE never restarts an operation.
- Signed corner: most-negative / -1 gives quotient = most-negative (wraps, no trap) and remainder 0.
- Unsigned mode never negates. Magnitude of the most-negative value is handled as an unsigned WIDTH-bit value.

Test Plan:
1. WIDTH=32, DIV unsigned 100/7, start held -> ready_o at E33, result 0x00000002_0000000E, div_by_zero_o=0; drop start -> ready_o=0 one cycle later.
2. DIV signed -7/2 -> result 0xFFFFFFFF_FFFFFFFD (rem -1, quo -3).
   - Also 0x80000000 / 0xFFFFFFFF signed -> 0x00000000_80000000.
3. DIV 5/0 -> ready_o at E2, div_by_zero_o=1, result 0; busy_o=1 during DZERO and DONE.
4. MULT signed -3*5 -> 0xFFFFFFFF_FFFFFFF1 at E33.
   - MULT unsigned 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE_00000001.
5. Annul at E10 of a DIV -> IDLE at E11, ready_o never rises. A new start then completes correctly.
   - Repeat with rst=1 at E10 -> all outputs 0 next cycle.
6. WIDTH=8 build, DIV unsigned 200/3 -> result 0x0242 at E9.
   - Change operands during RUN -> result unchanged.
